booth_radix4_seq_mult: RTL and testbench
========================================

BOOTH_RADIX4_SEQ_MULT -- requirements
Module: booth_radix4_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and at least 4.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 Start  input  1  request pulse; sampled only in IDLE.
REQ-005 Multiplicand  input  WIDTH  signed two's-complement operand A.
REQ-006 Multiplier  input  WIDTH  signed two's-complement operand B.
REQ-007 Busy  output  1  high in LOAD, RUN and DONE.
REQ-008 Done  output  1  one-cycle pulse; high only while in DONE.
REQ-009 Product  output  2*WIDTH  signed A*B; holds its value until the next accepted Start.

Function
REQ-010 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-011 Transitions: IDLE->LOAD on Start=1; LOAD->RUN always; RUN->DONE after WIDTH/2 RUN cycles; DONE->IDLE always.
REQ-012 LOAD SHALL capture Multiplicand and Multiplier, clear the accumulator and set digit counter i=0; operand changes after capture SHALL have no effect.
REQ-013 Each RUN cycle SHALL recode one radix-4 digit from triplet (B[2i+1], B[2i], B[2i-1]), with B[-1]=0.
REQ-014 Recoder outputs: SNGL = B[2i] xor B[2i-1]; DBL = (B[2i+1] & ~B[2i] & ~B[2i-1]) | (~B[2i+1] & B[2i] & B[2i-1]); NEG = B[2i+1].
REQ-015 The partial-product row SHALL be WIDTH+1 bits wide.
REQ-016 Each row bit j SHALL be (SNGL & A[j]) | (DBL & A[j-1]), XORed with NEG.
REQ-017 The row SHALL use A sign-extended by one bit, with A[-1]=0.
REQ-018 When NEG=1, a +1 SHALL be injected as carry-in at row weight 2^(2i).
REQ-019 The row SHALL be sign-extended to 2*WIDTH bits, shifted left by 2i and added modulo 2^(2*WIDTH) into the accumulator.
REQ-020 Digit counter i SHALL increment by 1 per RUN cycle, from 0 to WIDTH/2-1.
REQ-021 On the RUN->DONE edge, Product SHALL be loaded from the final accumulator; Product SHALL NOT change at any other time except reset.
REQ-022 Latency: for Start sampled at edge k, Done SHALL be high in the cycle after edge k+1+WIDTH/2 (WIDTH=8: high after edge k+5).
REQ-023 The next Start SHALL be sampled no earlier than the edge that returns the FSM to IDLE; throughput is one product per WIDTH/2+3 cycles.
REQ-024 Start in LOAD, RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 The most-negative operand (-2^(WIDTH-1)) on either input SHALL produce an exact result; no overflow is possible within 2*WIDTH bits.

Reset
REQ-026 RST=1 SHALL force the state to IDLE immediately, independent of CLK.
REQ-027 RST=1 SHALL clear to zero: Busy, Done, Product, the accumulator, the digit counter and the operand registers.
REQ-028 Assertion of RST during RUN SHALL abort the operation: no Done pulse, and Product reads 0.
REQ-029 After RST deasserts, the first Start SHALL be accepted normally.

Structure
REQ-030 Package booth_pkg SHALL hold the state enumeration, the default WIDTH and the recode-digit constants (0, +1, +2, -1, -2).
REQ-031 Sub-module booth_recoder (combinational) SHALL map a 3-bit triplet to SNGL, DBL and NEG.
REQ-032 The per-bit row logic SHALL instantiate the team's existing Booth decoder bit cell WIDTH+1 times.
REQ-033 Exactly one adder SHALL be used, shared across all RUN cycles.

Verification (WIDTH=8)
REQ-034 A=3, B=5, Start pulse -> Done after 5 edges, Product=0x000F, Busy high for 6 cycles.
REQ-035 A=-128, B=-128 -> Product=0x4000; A=127, B=-128 -> Product=0xC080.
REQ-036 A=0, B=-1 -> Product=0x0000; A=-1, B=-1 -> Product=0x0001.
REQ-037 Start held high continuously with new operands each cycle -> exactly one Done per 7 cycles, each result matching the operands captured in LOAD.
REQ-038 RST pulsed mid-RUN (i=2) -> Busy=0 and Product=0 immediately, no Done; next Start with A=6, B=-7 -> Product=0xFFD6.
REQ-039 Random sweep of 10k operand pairs -> every Product equals the signed reference A*B.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package booth_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Signed values of the five radix-4 Booth digits.
  localparam logic signed [2:0] DIG_ZERO = 3'sd0;
  localparam logic signed [2:0] DIG_P1   = 3'sd1;
  localparam logic signed [2:0] DIG_P2   = 3'sd2;
  localparam logic signed [2:0] DIG_M1   = -3'sd1;
  localparam logic signed [2:0] DIG_M2   = -3'sd2;

endpackage

// File: rtl/booth_dec_bit.sv
// Booth decoder bit cell: one partial-product bit from A[j], A[j-1] and digit controls.
// Latency: combinational.
// Backpressure: none.
module booth_dec_bit (
  input  logic sngl,
  input  logic dbl,
  input  logic neg,
  input  logic a_cur,
  input  logic a_prev,
  output logic pp
);

  // Select A or 2A, then invert for negative digits (the +1 is added elsewhere).
  always_comb begin
    pp = ((sngl & a_cur) | (dbl & a_prev)) ^ neg;
  end

endmodule

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: multiplier triplet -> single/double/negate controls.
// Latency: combinational.
// Backpressure: none.
module booth_recoder (
  input  logic [2:0] triplet,
  output logic       sngl,
  output logic       dbl,
  output logic       neg
);

  // triplet = {B[2i+1], B[2i], B[2i-1]}
  always_comb begin
    sngl = triplet[1] ^ triplet[0];
    dbl  = (triplet[2] & ~triplet[1] & ~triplet[0]) |
           (~triplet[2] & triplet[1] & triplet[0]);
    neg  = triplet[2];
  end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential signed multiplier retiring one radix-4 Booth digit per RUN cycle.
// Latency: Done in the cycle after edge k+1+WIDTH/2 for Start sampled at edge k.
// Backpressure: none; Start is only sampled in IDLE, never queued.
module booth_radix4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PSW  = $clog2(WIDTH + 1);
  localparam int PW   = 2 * WIDTH;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]    acc, sum, row_sh, cin_sh;
  logic [CW-1:0]    cnt;
  logic [PSW-1:0]   pos;
  logic             last_digit;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH+1:0] a_ext;
  logic [2:0]       triplet;
  logic             sngl, dbl, neg;
  logic [WIDTH:0]   row;

  // pos = 2i, the weight of the current digit
  assign pos        = PSW'({cnt, 1'b0});
  assign last_digit = (cnt == CW'(NDIG - 1));

  // B with B[-1]=0 appended; A sign-extended by one bit with A[-1]=0 appended
  assign b_ext   = {b_reg, 1'b0};
  assign a_ext   = {a_reg[WIDTH-1], a_reg, 1'b0};
  assign triplet = b_ext[pos +: 3];

  booth_recoder u_recoder (
    .triplet (triplet),
    .sngl    (sngl),
    .dbl     (dbl),
    .neg     (neg)
  );

  // One decoder cell per row bit; a_ext[j+1] is A[j], a_ext[j] is A[j-1]
  for (genvar j = 0; j <= WIDTH; j++) begin : g_row
    booth_dec_bit u_bit (
      .sngl   (sngl),
      .dbl    (dbl),
      .neg    (neg),
      .a_cur  (a_ext[j+1]),
      .a_prev (a_ext[j]),
      .pp     (row[j])
    );
  end

  assign row_sh = {{(WIDTH-1){row[WIDTH]}}, row} << pos;
  assign cin_sh = {{(PW-1){1'b0}}, neg} << pos;

  // The single shared accumulator adder: acc + shifted row + two's-complement carry-in
  always_comb begin
    sum = acc + row_sh + cin_sh;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (last_digit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    Busy = (state != S_IDLE);
    Done = (state == S_DONE);
  end

  // Datapath: capture operands in LOAD, accumulate in RUN, publish on the last digit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      Product <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          a_reg <= Multiplicand;
          b_reg <= Multiplier;
          acc   <= '0;
          cnt   <= '0;
        end
        S_RUN: begin
          acc <= sum;
          if (last_digit) Product <= sum;
          else            cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Randomized scoreboard bench for booth_radix4_seq_mult at WIDTH=8.
// Latency: checks Done timing against the Start acceptance edge.
// Backpressure: models Start being ignored while busy.
module tb_booth_radix4_seq_mult;

  localparam int W    = 8;
  localparam int NDIG = W / 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic           Start;
  logic [W-1:0]   Multiplicand;
  logic [W-1:0]   Multiplier;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] Product;

  booth_radix4_seq_mult #(.WIDTH(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Busy         (Busy),
    .Done         (Done),
    .Product      (Product)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2*W-1:0] prod;
    int             edge_n;
  } exp_t;

  exp_t           q[$];
  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  int             free_edge = 0;
  bit             cap_pending = 0;
  logic [2*W-1:0] last_prod = '0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol-level reference: which edges accept Start, when operands are taken, when Done is due
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      free_edge   = cyc;
      cap_pending = 0;
      q.delete();
    end else begin
      cyc++;
      if (cap_pending) begin
        exp_t e;
        e.prod   = ref_mul(Multiplicand, Multiplier);
        e.edge_n = cyc + NDIG;
        q.push_back(e);
        cap_pending = 0;
      end
      if (Start && cyc > free_edge) begin
        cap_pending = 1;
        free_edge   = cyc + NDIG + 2;
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the scoreboard
  always @(negedge CLK) begin
    if (RST) last_prod = '0;
    chk("busy", Busy, (cyc < free_edge) ? 1 : 0);
    if (Done) begin
      if (q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product_at_done", Product, e.prod);
        chk("done_edge", cyc, e.edge_n);
        last_prod = e.prod;
      end
    end else if (q.size() > 0 && cyc >= q[0].edge_n) begin
      chk("done_missing", 0, 1);
      void'(q.pop_front());
    end
    chk("product_hold", Product, last_prod);
  end

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    Start = 1'b1; Multiplicand = a; Multiplier = b;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    Multiplicand = W'($urandom); Multiplier = W'($urandom);
    repeat (NDIG + 1) begin
      @(negedge CLK);
      Multiplicand = W'($urandom); Multiplier = W'($urandom);
    end
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; Multiplicand = '0; Multiplier = '0;
    #1;
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_product", Product, 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;

    do_mul(8'd3, 8'd5);       chk("dir_3x5", Product, 16'h000F);
    do_mul(8'h80, 8'h80);     chk("dir_m128xm128", Product, 16'h4000);
    do_mul(8'd127, 8'h80);    chk("dir_127xm128", Product, 16'hC080);
    do_mul(8'd0, 8'hFF);      chk("dir_0xm1", Product, 16'h0000);
    do_mul(8'hFF, 8'hFF);     chk("dir_m1xm1", Product, 16'h0001);
    do_mul(8'h80, 8'd127);    chk("dir_m128x127", Product, 16'hC080);

    // Abort mid-RUN at digit 2
    @(negedge CLK);
    Start = 1'b1; Multiplicand = 8'd5; Multiplier = 8'd9;
    @(negedge CLK);
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_product", Product, 0);
    @(negedge CLK);
    #2 RST = 1'b0;
    repeat (NDIG + 3) @(negedge CLK);
    chk("abort_product_after", Product, 0);
    do_mul(8'd6, 8'hF9);      chk("dir_6xm7", Product, 16'hFFD6);

    // Start held high with fresh operands every cycle; also the 10k random sweep
    @(negedge CLK);
    Start = 1'b1;
    repeat (10000 * (NDIG + 3)) begin
      Multiplicand = W'($urandom); Multiplier = W'($urandom);
      @(negedge CLK);
    end
    Start = 1'b0;
    repeat (NDIG + 8) @(negedge CLK);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
